// File: rtl/mem_responder.sv
// Word-addressed memory slave for the CPU memory bus with configurable wait states.
// Optional address range checking is enabled by defining MEM_RESPONDER_ADDR_CHECK_EN.
module mem_responder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_err,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   accept_c;
    logic                   commit_c;
    logic                   we_c;
    logic [IDX_W-1:0]       idx_c;
    logic [DATA_WIDTH-1:0]  wdata_c;
    logic                   err_c;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[1:0], mem_addr[ADDR_WIDTH-1:IDX_W+2]};

    // With zero wait states the commit edge is also the accept edge, so use live inputs in IDLE
    assign we_c    = (state_q == S_IDLE) ? mem_we : we_q;
    assign idx_c   = (state_q == S_IDLE) ? mem_addr[IDX_W+1:2] : idx_q;
    assign wdata_c = (state_q == S_IDLE) ? mem_wdata : wdata_q;

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    logic err_q;
    assign err_c = (state_q == S_IDLE) ? (|mem_addr[ADDR_WIDTH-1:IDX_W+2]) : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            if (accept_c) begin
                err_q <= |mem_addr[ADDR_WIDTH-1:IDX_W+2];
            end
            mem_err <= (state_d == S_ACK) && err_c;
        end
    end
`else
    assign err_c   = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Next-state and wait counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_W'(WAIT_STATES);
                    state_d  = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        commit_c = (state_d == S_ACK) && (state_q != S_ACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_ack <= (state_d == S_ACK);
            busy    <= (state_d != S_IDLE);
            if (accept_c) begin
                we_q    <= mem_we;
                idx_q   <= mem_addr[IDX_W+1:2];
                wdata_q <= mem_wdata;
            end
            if (commit_c && !we_c) begin
                mem_rdata <= err_c ? DATA_WIDTH'(32'hDEADBEEF) : mem[idx_c];
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (rst_n && commit_c && we_c && !err_c) begin
            mem[idx_c] <= wdata_c;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (0 and 3 wait states) against a
// transaction-level memory model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  req, we, ack, err, busy;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [2][DEPTH];
    bit          known [2][DEPTH];
    logic [31:0] last_rd [2];
    bit          last_ok [2];

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_ack(ack[0]), .mem_rdata(rdata[0]), .mem_err(err[0]),
        .busy(busy[0])
    );

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_ack(ack[1]), .mem_rdata(rdata[1]), .mem_err(err[1]),
        .busy(busy[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit oob(input logic [31:0] a);
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
        return a >= 32'(DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // One full transaction with latency, busy, err, rdata and idle-after-ack checks
    task automatic do_txn(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input bit toggle, input string name);
        int          lat = 0;
        int          busy_n = 0;
        bit          got = 0;
        bit          exp_err;
        bit          exp_known = 0;
        logic [31:0] exp_rd = '0;
        exp_err = oob(a);
        if (!w) begin
            if (exp_err) begin
                exp_rd = 32'hDEADBEEF; exp_known = 1;
            end else begin
                exp_rd = model[d][widx(a)]; exp_known = known[d][widx(a)];
            end
        end
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy[d] === 1'b1) busy_n++;
            if (ack[d] === 1'b1) got = 1;
            else if (toggle) begin
                addr[d] = $urandom; wdata[d] = $urandom;
            end
        end
        req[d] = 1'b0;
        n_checks++;
        if (!got || lat != 1 + ws(d)) begin
            n_fail++;
            $display("FAIL %s latency dut%0d: got %0d (ack seen %0d) expected %0d", name, d, lat, got, 1 + ws(d));
        end
        n_checks++;
        if (busy_n != 1 + ws(d)) begin
            n_fail++;
            $display("FAIL %s busy_cycles dut%0d: got %0d expected %0d", name, d, busy_n, 1 + ws(d));
        end
        n_checks++;
        if (err[d] !== exp_err) begin
            n_fail++;
            $display("FAIL %s mem_err dut%0d: got %b expected %b", name, d, err[d], exp_err);
        end
        if (!w && exp_known) begin
            n_checks++;
            if (rdata[d] !== exp_rd) begin
                n_fail++;
                $display("FAIL %s rdata dut%0d addr %h: got %h expected %h", name, d, a, rdata[d], exp_rd);
            end
        end
        if (w && last_ok[d]) begin
            n_checks++;
            if (rdata[d] !== last_rd[d]) begin
                n_fail++;
                $display("FAIL %s rdata_hold dut%0d: got %h expected %h", name, d, rdata[d], last_rd[d]);
            end
        end
        if (!w) begin
            last_rd[d] = exp_rd; last_ok[d] = exp_known;
        end
        if (w && !exp_err) begin
            model[d][widx(a)] = wd; known[d][widx(a)] = 1;
        end
        @(negedge clk);
        n_checks++;
        if (ack[d] !== 1'b0 || busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_ack dut%0d: ack %b busy %b expected 0 0", name, d, ack[d], busy[d]);
        end
    endtask

    task automatic test_reset();
        req = '0; we = '0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wdata[d] = '0; last_rd[d] = '0; last_ok[d] = 1;
        end
        rst_n = 2'b11;
        #2 rst_n = 2'b00;
        #3;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ack[d] !== 1'b0 || busy[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: ack %b busy %b err %b rdata %h expected all 0",
                         d, ack[d], busy[d], err[d], rdata[d]);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 2'b11;
    endtask

    task automatic test_basic();
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, 32'h10, 32'h12345678, d == 1, "basic_wr");
            do_txn(d, 1'b0, 32'h10, 32'h0, d == 1, "basic_rd");
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'hA5A5A5A5;
        while (ack[0] !== 1'b1 && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (cyc != 1) begin
            n_fail++;
            $display("FAIL b2b first_ack: got %0d expected 1", cyc);
        end
        we[0] = 1'b0; wdata[0] = 32'h0;
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
        end while (ack[0] !== 1'b1 && cyc < 20);
        req[0] = 1'b0;
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL b2b second_ack: got %0d cycles after first, expected 2", cyc);
        end
        n_checks++;
        if (rdata[0] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL b2b rdata: got %h expected a5a5a5a5", rdata[0]);
        end
        model[0][0] = 32'hA5A5A5A5; known[0][0] = 1;
        last_rd[0] = 32'hA5A5A5A5; last_ok[0] = 1;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        bit ack_seen = 0;
        do_txn(1, 1'b1, 32'h20, 32'h1, 1'b0, "prewrite");
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0; req[1] = 1'b0;
        #1;
        n_checks++;
        if (ack[1] !== 1'b0 || busy[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wait outputs: ack %b busy %b err %b rdata %h expected all 0",
                     ack[1], busy[1], err[1], rdata[1]);
        end
        repeat (4) begin
            @(negedge clk);
            if (ack[1] !== 1'b0) ack_seen = 1;
        end
        rst_n[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack[1] !== 1'b0) ack_seen = 1;
        end
        n_checks++;
        if (ack_seen) begin
            n_fail++;
            $display("FAIL rst_wait no_ack: got ack after abort, expected none");
        end
        last_rd[1] = '0; last_ok[1] = 1;
        do_txn(1, 1'b0, 32'h20, 32'h0, 1'b0, "rst_wait_rd");
    endtask

    task automatic test_addr_range();
        do_txn(0, 1'b1, 32'h400, 32'h5, 1'b0, "oob_wr");
        do_txn(0, 1'b0, 32'h0, 32'h0, 1'b0, "oob_rd0");
        do_txn(0, 1'b0, 32'h400, 32'h0, 1'b0, "oob_rd400");
    endtask

    task automatic test_low_bits();
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, 32'h3FC, $urandom, 1'b0, "low_wr");
            do_txn(d, 1'b0, 32'h3FD, 32'h0, 1'b0, "low_rd");
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) do_txn(d, 1'b1, 32'(i * 4), $urandom, 1'b1, "rnd_init");
            for (int i = 0; i < 40; i++) begin
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a | 32'h400;
                do_txn(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, "rnd");
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_in_wait();
        test_addr_range();
        test_low_bits();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
